// File: rtl/top_level_pattern_counter.sv
// -----------------------------------------------------------------------------
// top_level_pattern_counter
//
// Purpose:
//   Counts occurrences of a 5-bit pattern P inside a 32-byte message held in a
//   256x8 data memory (dm1.core), then writes three result bytes back into
//   the same memory:
//     core[33] = CTB : in-byte windows equal to P            (0..128)
//     core[34] = CTO : bytes holding at least one such window (0..32)
//     core[35] = CTS : all 252 windows of the 256-bit string  (0..252)
//   The message is core[0..31], byte 0 most significant. P is core[32][7:3].
//
// Ports:
//   clk   in   1  rising-edge clock
//   reset in   1  asynchronous, active-low reset
//   start in   1  run request, honoured only in IDLE or DONE
//   done  out  1  high in DONE; rises 37 edges after the accepting edge
//
// Timing of one run (edge 0 = edge that accepts start):
//   edge 1        LOADP latches P
//   edges 2..33   SCAN, one message byte per edge
//   edges 34..36  WR33, WR34, WR35 write CTB, CTO, CTS
//   edge 37       done goes high (registered from the DONE state)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// data_memory
//
// Purpose:
//   256x8 single-port memory, combinational read, synchronous write.
//
// Ports:
//   clk   in   1  write clock
//   we    in   1  write enable
//   addr  in   8  shared read/write address
//   wdata in   8  write data
//   rdata out  8  combinational read data at addr
// -----------------------------------------------------------------------------
module data_memory (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] core [0:255];

    // NOTE: the array has no reset on purpose; its contents are preloaded
    // externally and must survive a reset of the controller.
    always_ff @(posedge clk) begin
        if (we) begin
            core[addr] <= wdata;
        end
    end

    assign rdata = core[addr];

endmodule

module top_level_pattern_counter (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    typedef enum logic [2:0] {
        IDLE,
        LOADP,
        SCAN,
        WR33,
        WR34,
        WR35,
        DONE
    } state_t;

    localparam logic [7:0] ADDR_PAT = 8'd32;
    localparam logic [7:0] ADDR_CTB = 8'd33;
    localparam logic [7:0] ADDR_CTO = 8'd34;
    localparam logic [7:0] ADDR_CTS = 8'd35;
    localparam logic [4:0] LAST_IDX = 5'd31;

    state_t     state;
    logic [4:0] idx;       // message byte being scanned
    logic [4:0] pat;       // latched pattern P
    logic [7:0] prev;      // previously scanned byte, for cross-byte windows
    logic [7:0] ctb;
    logic [7:0] cto;
    logic [7:0] cts;

    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [2:0] in_cnt;    // matches inside the current byte
    logic [2:0] cross_cnt; // matches straddling previous/current byte

    data_memory dm1 (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Number of the four 5-bit windows [7:3],[6:2],[5:1],[4:0] of w equal to p.
    function automatic logic [2:0] count_windows(input logic [7:0] w,
                                                 input logic [4:0] p);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (w[k +: 5] == p) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

    // Memory port steering. The write enable is decoded from the state, so an
    // asynchronous reset drops it immediately and no partial write lands.
    // NOTE: every output of this block gets a default first so no latch is
    // inferred for the states that do not touch the memory.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        case (state)
            LOADP: mem_addr = ADDR_PAT;
            SCAN:  mem_addr = {3'b000, idx};
            WR33: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_CTB;
                mem_wdata = ctb;
            end
            WR34: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_CTO;
                mem_wdata = cto;
            end
            WR35: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_CTS;
                mem_wdata = cts;
            end
            default: ;
        endcase
    end

    // Window matches for the byte currently on the read port. The cross-byte
    // string {prev[3:0], cur[7:4]} has exactly the four windows that span the
    // byte boundary; there is no boundary before byte 0.
    always_comb begin
        in_cnt    = count_windows(mem_rdata, pat);
        cross_cnt = (idx == 5'd0) ? 3'd0
                                  : count_windows({prev[3:0], mem_rdata[7:4]}, pat);
    end

    // NOTE: all state here is sequential and therefore uses non-blocking
    // assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= 5'd0;
            pat   <= 5'd0;
            prev  <= 8'd0;
            ctb   <= 8'd0;
            cto   <= 8'd0;
            cts   <= 8'd0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx   <= 5'd0;
                        prev  <= 8'd0;
                        ctb   <= 8'd0;
                        cto   <= 8'd0;
                        cts   <= 8'd0;
                        done  <= 1'b0;
                        state <= LOADP;
                    end else if (state == DONE) begin
                        // One-edge lag after WR35 gives the 37-edge latency.
                        done <= 1'b1;
                    end
                end

                LOADP: begin
                    pat   <= mem_rdata[7:3];
                    state <= SCAN;
                end

                SCAN: begin
                    ctb  <= ctb + {5'd0, in_cnt};
                    cto  <= cto + {7'd0, (in_cnt != 3'd0)};
                    cts  <= cts + {5'd0, in_cnt} + {5'd0, cross_cnt};
                    prev <= mem_rdata;
                    idx  <= idx + 5'd1;
                    if (idx == LAST_IDX) begin
                        state <= WR33;
                    end
                end

                WR33: state <= WR34;
                WR34: state <= WR35;
                WR35: state <= DONE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_level_pattern_counter.sv
// -----------------------------------------------------------------------------
// Directed testbench for top_level_pattern_counter. Preloads dm1.core
// hierarchically, runs the pattern counter and compares done latency and the
// three result bytes against hand-computed values.
// -----------------------------------------------------------------------------
module tb_top_level_pattern_counter;

    logic clk;
    logic reset;
    logic start;
    logic done;

    int checks;
    int errors;

    localparam logic [7:0] MARK   = 8'hAA;
    localparam logic [7:0] MARK36 = 8'h5A;
    localparam logic [7:0] MARKFF = 8'hC3;

    top_level_pattern_counter dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_msg(input logic [7:0] v);
        for (int i = 0; i < 32; i++) begin
            dut.dm1.core[i] = v;
        end
    endtask

    // Pattern byte plus sentinel bytes around the result area.
    task automatic set_ctrl(input logic [4:0] p);
        dut.dm1.core[32]  = {p, 3'b101};
        dut.dm1.core[33]  = MARK;
        dut.dm1.core[34]  = MARK;
        dut.dm1.core[35]  = MARK;
        dut.dm1.core[36]  = MARK36;
        dut.dm1.core[255] = MARKFF;
    endtask

    // Issues start at a clean edge and leaves the bench #1 after that edge.
    task automatic accept_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // glitch_at > 0 raises start again for one edge, that many edges in.
    task automatic run_case(input string tag, input logic [4:0] p,
                            input logic [7:0] e_ctb, input logic [7:0] e_cto,
                            input logic [7:0] e_cts, input int glitch_at);
        int edges;
        bit seen;
        set_ctrl(p);
        accept_start();
        check({tag, "/done_low_after_start"}, {31'd0, done}, 32'd0);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            start = (edges == glitch_at);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "/done_latency"}, edges, 37);
        check({tag, "/ctb"}, dut.dm1.core[33], e_ctb);
        check({tag, "/cto"}, dut.dm1.core[34], e_cto);
        check({tag, "/cts"}, dut.dm1.core[35], e_cts);
        check({tag, "/pattern_byte_kept"}, dut.dm1.core[32], {p, 3'b101});
        check({tag, "/byte36_kept"}, dut.dm1.core[36], MARK36);
        check({tag, "/byte255_kept"}, dut.dm1.core[255], MARKFF);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        start  = 1'b0;
        reset  = 1'b0;
        #1;
        check("reset/done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle/done", {31'd0, done}, 32'd0);

        fill_msg(8'h00);
        run_case("p00000_all00", 5'b00000, 8'd128, 8'd32, 8'd252, 0);

        fill_msg(8'h55);
        run_case("p10101_all55", 5'b10101, 8'd64, 8'd32, 8'd126, 0);

        fill_msg(8'h00);
        run_case("p11111_all00", 5'b11111, 8'd0, 8'd0, 8'd0, 0);

        fill_msg(8'hFF);
        run_case("p11111_allFF", 5'b11111, 8'd128, 8'd32, 8'd252, 0);

        fill_msg(8'h00);
        dut.dm1.core[5] = 8'hF8;
        run_case("p11111_single", 5'b11111, 8'd1, 8'd1, 8'd1, 0);

        fill_msg(8'hFF);
        dut.dm1.core[3] = 8'h01;
        dut.dm1.core[4] = 8'h40;
        run_case("p00101_cross", 5'b00101, 8'd0, 8'd0, 8'd1, 0);

        // Single match in the low window of byte 0; nothing precedes byte 0.
        fill_msg(8'h00);
        dut.dm1.core[0] = 8'h10;
        run_case("p10000_byte0", 5'b10000, 8'd1, 8'd1, 8'd1, 0);

        // Start pulsed mid-SCAN must be ignored.
        fill_msg(8'h55);
        run_case("start_in_scan", 5'b10101, 8'd64, 8'd32, 8'd126, 8);

        // Reset 10 edges into a run: nothing written, then idle until start.
        fill_msg(8'h00);
        set_ctrl(5'b00000);
        accept_start();
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort10/done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort10/core33", dut.dm1.core[33], MARK);
        check("abort10/core34", dut.dm1.core[34], MARK);
        check("abort10/core35", dut.dm1.core[35], MARK);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort10/idle_done", {31'd0, done}, 32'd0);
        check("abort10/idle_core33", dut.dm1.core[33], MARK);
        run_case("after_abort", 5'b00000, 8'd128, 8'd32, 8'd252, 0);

        // Reset right after the CTB write: CTB stays, CTO/CTS never written.
        fill_msg(8'h00);
        set_ctrl(5'b00000);
        accept_start();
        repeat (34) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort34/done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort34/core33", dut.dm1.core[33], 8'd128);
        check("abort34/core34", dut.dm1.core[34], MARK);
        check("abort34/core35", dut.dm1.core[35], MARK);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
